// File: rtl/stage_sequencer_pkg.sv
// stage_sequencer_pkg
//   Shared definitions for the Y86 SEQ stage sequencer: icode values, FSM
//   state encodings, processor status codes and the icode classification
//   helpers (which instructions touch data memory, which write back, which
//   write to memory).
package stage_sequencer_pkg;

    // Y86 instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EXECUTE   = 4'd3,
        ST_MEMORY    = 4'd4,
        ST_WRITEBACK = 4'd5,
        ST_PCUPD     = 4'd6,
        ST_HALTED    = 4'd7,
        ST_FAULT     = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_e;

    // Anything above POPL is not a Y86 instruction.
    function automatic logic is_valid_icode(input logic [3:0] ic);
        return (ic <= I_POPL);
    endfunction

    // Instructions that need a data memory access.
    function automatic logic mem_needed(input logic [3:0] ic);
        case (ic)
            I_RMMOVL, I_MRMOVL, I_CALL, I_RET, I_PUSHL, I_POPL: return 1'b1;
            I_HALT, I_NOP, I_RRMOVL, I_IRMOVL, I_OPL, I_JXX:     return 1'b0;
            default:                                             return 1'b0;
        endcase
    endfunction

    // Instructions that write a register in the write-back stage.
    function automatic logic wb_needed(input logic [3:0] ic);
        case (ic)
            I_RRMOVL, I_IRMOVL, I_MRMOVL, I_OPL,
            I_CALL, I_RET, I_PUSHL, I_POPL:                      return 1'b1;
            I_HALT, I_NOP, I_RMMOVL, I_JXX:                      return 1'b0;
            default:                                             return 1'b0;
        endcase
    endfunction

    // Data memory accesses that are writes; all others are reads.
    function automatic logic mem_write(input logic [3:0] ic);
        case (ic)
            I_RMMOVL, I_CALL, I_PUSHL: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stage_sequencer_ack_watchdog.sv
// ack_watchdog
//   Counts wait cycles while a memory request is outstanding and flags when
//   the allowed number of wait cycles has been used up.
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   clear_i    restart the count (held while no request is outstanding)
//   en_i       a request cycle is in progress
//   timeout_o  high in the cycle that is ACK_TIMEOUT wait cycles after the
//              first request cycle; without an ack in that cycle the request
//              has exceeded its budget
module ack_watchdog #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam int CW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(ACK_TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The first request cycle sees cnt_q = 0, so cnt_q is the number of
    // wait cycles already spent before the current one. Saturates at LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = (cnt_q == LIMIT);

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer
//   Multi-cycle control FSM for the Y86 SEQ core. Steps one instruction at a
//   time through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD, skipping
//   MEMORY/WRITEBACK when the icode does not need them, and reports status.
// Ports:
//   CLK, RST_N           clock (rising edge), async active-low reset
//   run                  start request, sampled in IDLE
//   icode, imem_ack      fetched instruction code, valid while imem_ack = 1
//   dmem_ack, dmem_err   data memory completion / address error
//   imem_req             high in every FETCH cycle
//   dmem_req, dmem_wr    high in every MEMORY cycle; dmem_wr = store access
//   decode_en, exec_en,
//   wb_en, pc_we         one-cycle stage enables
//   stat                 AOK / HLT / ADR / INS
//   busy                 high outside IDLE, HALTED and FAULT
//   cycle_cnt            cycles with busy = 1 (wraps)
//   instr_cnt            retired instructions (wraps)
//
// Handshake: a request (imem_req / dmem_req) stays high from the first
// cycle of its state until the memory answers; the answer is taken in any
// cycle the request is high, and the request drops in the following cycle.
// If no answer arrives within ACK_TIMEOUT wait cycles the core faults with
// ADR. dmem_err is only looked at while dmem_req is high and beats dmem_ack.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int CNT_WID     = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               run,
    input  logic [3:0]         icode,
    input  logic               imem_ack,
    input  logic               dmem_ack,
    input  logic               dmem_err,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               dmem_wr,
    output logic               decode_en,
    output logic               exec_en,
    output logic               wb_en,
    output logic               pc_we,
    output logic [1:0]         stat,
    output logic               busy,
    output logic [CNT_WID-1:0] cycle_cnt,
    output logic [CNT_WID-1:0] instr_cnt
);

    state_e             state_q, state_d;
    stat_e              stat_q, stat_d;
    logic [3:0]         icode_q;
    logic               imem_req_q, dmem_req_q, dmem_wr_q;
    logic               decode_en_q, exec_en_q, wb_en_q, pc_we_q, busy_q;
    logic [CNT_WID-1:0] cycle_cnt_q, instr_cnt_q;

    logic wait_state;
    logic ack_timeout;

    assign wait_state = (state_q == ST_FETCH) || (state_q == ST_MEMORY);

    // Holding clear outside the wait states means the counter is zero on
    // every entry to FETCH or MEMORY.
    ack_watchdog #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_watchdog (
        .clk_i    (CLK),
        .rst_ni   (RST_N),
        .clear_i  (!wait_state),
        .en_i     (wait_state),
        .timeout_o(ack_timeout)
    );

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // An ack in the last allowed cycle still counts.
                if (imem_ack) begin
                    if (!is_valid_icode(icode)) begin
                        state_d = ST_FAULT;
                        stat_d  = STAT_INS;
                    end else begin
                        state_d = ST_DECODE;
                    end
                end else if (ack_timeout) begin
                    state_d = ST_FAULT;
                    stat_d  = STAT_ADR;
                end
            end
            ST_DECODE: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (mem_needed(icode_q))     state_d = ST_MEMORY;
                else if (wb_needed(icode_q)) state_d = ST_WRITEBACK;
                else                         state_d = ST_PCUPD;
            end
            ST_MEMORY: begin
                if (dmem_err) begin
                    state_d = ST_FAULT;
                    stat_d  = STAT_ADR;
                end else if (dmem_ack) begin
                    state_d = wb_needed(icode_q) ? ST_WRITEBACK : ST_PCUPD;
                end else if (ack_timeout) begin
                    state_d = ST_FAULT;
                    stat_d  = STAT_ADR;
                end
            end
            ST_WRITEBACK: state_d = ST_PCUPD;
            ST_PCUPD: begin
                if (icode_q == I_HALT) begin
                    state_d = ST_HALTED;
                    stat_d  = STAT_HLT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = state_q;  // HALTED and FAULT are sticky
        endcase
    end

    // Outputs are decoded from the next state so they line up with the
    // state they belong to while staying registered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            stat_q      <= STAT_AOK;
            icode_q     <= '0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_wr_q   <= 1'b0;
            decode_en_q <= 1'b0;
            exec_en_q   <= 1'b0;
            wb_en_q     <= 1'b0;
            pc_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stat_q      <= stat_d;
            if ((state_q == ST_FETCH) && imem_ack) begin
                icode_q <= icode;
            end
            imem_req_q  <= (state_d == ST_FETCH);
            dmem_req_q  <= (state_d == ST_MEMORY);
            dmem_wr_q   <= (state_d == ST_MEMORY) && mem_write(icode_q);
            decode_en_q <= (state_d == ST_DECODE);
            exec_en_q   <= (state_d == ST_EXECUTE);
            wb_en_q     <= (state_d == ST_WRITEBACK);
            pc_we_q     <= (state_d == ST_PCUPD);
            busy_q      <= (state_d != ST_IDLE) && (state_d != ST_HALTED) &&
                           (state_d != ST_FAULT);
            cycle_cnt_q <= cycle_cnt_q + CNT_WID'(busy_q);
            // Retire when leaving PCUPD; the count shows up the cycle after pc_we.
            if (state_q == ST_PCUPD) begin
                instr_cnt_q <= instr_cnt_q + 1'b1;
            end
        end
    end

    assign imem_req  = imem_req_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_wr   = dmem_wr_q;
    assign decode_en = decode_en_q;
    assign exec_en   = exec_en_q;
    assign wb_en     = wb_en_q;
    assign pc_we     = pc_we_q;
    assign stat      = stat_q;
    assign busy      = busy_q;
    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule
